// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data-cache miss/writeback controller.
package dcache_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WB        = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } dcache_state_e;

  // Byte i is taken from new_word where strb[i] is set, otherwise from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Miss/writeback FSM for a direct-mapped, one-word-line data cache; one request in flight.
// Define DCACHE_PERF_EN to add the perf_hit / perf_miss / perf_wb event counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 4
) (
  input  logic        clk,
`ifdef DCACHE_PERF_EN
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss,
  output logic [31:0] perf_wb,
`endif
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] arr_addr,
  input  logic        arr_hit,
  input  logic        arr_dirty,
  input  logic [31:0] arr_data,
  input  logic [31:0] arr_invalidate_addr,
  output logic [31:0] arr_write_data,
  output logic [3:0]  arr_write_strb,
  output logic        arr_write_valid,
  output logic        arr_write_access,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_write,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam logic [31:0] LINE_MASK  = ~(32'(LINE_SIZE) - 32'd1);
  localparam logic [31:0] INDEX_MASK = 32'(CACHE_SIZE) - 32'd1;

  dcache_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   vaddr_q, vaddr_d;
  logic [31:0]   vdata_q, vdata_d;

  assign arr_write_strb = 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'h0;
      vaddr_q <= 32'd0;
      vdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    write_d          = write_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    vaddr_d          = vaddr_q;
    vdata_d          = vdata_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = 32'd0;
    arr_addr         = addr_q;
    arr_write_data   = 32'd0;
    arr_write_valid  = 1'b0;
    arr_write_access = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = 32'd0;
    mem_req_write    = 1'b0;
    mem_req_wdata    = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        arr_addr  = req_addr;
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (arr_hit) begin
          resp_valid = 1'b1;
          state_d    = IDLE;
          if (write_q) begin
            arr_write_valid  = 1'b1;
            arr_write_access = 1'b1;
            arr_write_data   = byte_merge(arr_data, wdata_q, wstrb_q);
          end else begin
            resp_rdata = arr_data;
          end
        end else if (arr_dirty) begin
          // The victim shares the request's set, so its index bits come from the request.
          vaddr_d = ((arr_invalidate_addr & ~INDEX_MASK) | (addr_q & INDEX_MASK)) & LINE_MASK;
          vdata_d = arr_data;
          state_d = WB;
        end else begin
          state_d = FILL_REQ;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = vaddr_q;
        mem_req_wdata = vdata_q;
        if (mem_req_ready) begin
          state_d = FILL_REQ;
        end else begin
          state_d = WB;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q & LINE_MASK;
        if (mem_req_ready) begin
          state_d = FILL_WAIT;
        end else begin
          state_d = FILL_REQ;
        end
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          arr_write_valid  = 1'b1;
          arr_write_access = write_q;
          arr_write_data   = write_q ? byte_merge(mem_resp_rdata, wdata_q, wstrb_q)
                                     : mem_resp_rdata;
          resp_valid       = 1'b1;
          resp_rdata       = write_q ? 32'd0 : mem_resp_rdata;
          state_d          = IDLE;
        end else begin
          state_d = FILL_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q, perf_wb_q;

  // Event counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
      perf_wb_q   <= 32'd0;
    end else begin
      if (state_q == LOOKUP && arr_hit) begin
        perf_hit_q <= perf_hit_q + 32'd1;
      end
      if (state_q == LOOKUP && !arr_hit) begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
      if (state_q == WB && mem_req_ready) begin
        perf_wb_q <= perf_wb_q + 32'd1;
      end
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
  assign perf_wb   = perf_wb_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: behavioural array model plus response/memory/array-write scoreboards.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] arr_addr;
  logic        arr_hit, arr_dirty;
  logic [31:0] arr_data, arr_invalidate_addr, arr_write_data;
  logic [3:0]  arr_write_strb;
  logic        arr_write_valid, arr_write_access;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss, perf_wb;
`endif

  dcache_ctrl #(.CACHE_SIZE(1024), .LINE_SIZE(4)) dut (
    .clk(clk),
`ifdef DCACHE_PERF_EN
    .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_wb(perf_wb),
`endif
    .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .arr_addr(arr_addr), .arr_hit(arr_hit), .arr_dirty(arr_dirty), .arr_data(arr_data),
    .arr_invalidate_addr(arr_invalidate_addr), .arr_write_data(arr_write_data),
    .arr_write_strb(arr_write_strb), .arr_write_valid(arr_write_valid),
    .arr_write_access(arr_write_access),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Direct-mapped array model: 256 one-word lines, registered read, write on edge.
  logic        arr_clr, pl_en, pl_dirty;
  logic [31:0] pl_addr, pl_data;
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];
  logic        m_val   [256];
  logic        m_dirty [256];

  always @(posedge clk) begin
    logic [7:0] ri, wi;
    ri = arr_addr[9:2];
    arr_hit             <= m_val[ri] && (m_tag[ri] == arr_addr[31:10]);
    arr_dirty           <= m_val[ri] && m_dirty[ri];
    arr_data            <= m_data[ri];
    arr_invalidate_addr <= {m_tag[ri], ri, 2'b00};
    if (arr_clr) begin
      for (int i = 0; i < 256; i++) begin
        m_val[i]   <= 1'b0;
        m_dirty[i] <= 1'b0;
        m_tag[i]   <= 22'd0;
        m_data[i]  <= 32'd0;
      end
    end else if (pl_en) begin
      wi = pl_addr[9:2];
      m_val[wi] <= 1'b1; m_dirty[wi] <= pl_dirty; m_tag[wi] <= pl_addr[31:10]; m_data[wi] <= pl_data;
    end else if (arr_write_valid) begin
      wi = arr_addr[9:2];
      m_val[wi] <= 1'b1; m_dirty[wi] <= arr_write_access; m_tag[wi] <= arr_addr[31:10];
      m_data[wi] <= arr_write_data;
    end
  end

  typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] wdata; } mem_exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic access; } aw_exp_t;
  mem_exp_t    exp_mem_q[$];
  aw_exp_t     exp_aw_q[$];
  logic [31:0] exp_resp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic monitor();
    logic [31:0] er;
    mem_exp_t    em;
    aw_exp_t     ea;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resp_valid) begin
          n_checks++;
          if (exp_resp_q.size() == 0) begin
            n_fail++; $display("FAIL resp_unexpected: got rdata=%h, required no response", resp_rdata);
          end else begin
            er = exp_resp_q.pop_front();
            if (resp_rdata !== er) begin
              n_fail++; $display("FAIL resp_rdata: got %h required %h", resp_rdata, er);
            end
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          n_checks++;
          if (exp_mem_q.size() == 0) begin
            n_fail++; $display("FAIL mem_unexpected: got addr=%h write=%b, required no request", mem_req_addr, mem_req_write);
          end else begin
            em = exp_mem_q.pop_front();
            if (mem_req_addr !== em.addr || mem_req_write !== em.wr || (em.wr && mem_req_wdata !== em.wdata)) begin
              n_fail++;
              $display("FAIL mem_req: got addr=%h wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                       mem_req_addr, mem_req_write, mem_req_wdata, em.addr, em.wr, em.wdata);
            end
          end
        end
        if (arr_write_valid) begin
          n_checks++;
          if (exp_aw_q.size() == 0) begin
            n_fail++; $display("FAIL arr_write_unexpected: got addr=%h data=%h, required no write", arr_addr, arr_write_data);
          end else begin
            ea = exp_aw_q.pop_front();
            if (arr_addr !== ea.addr || arr_write_data !== ea.data || arr_write_access !== ea.access || arr_write_strb !== 4'h0) begin
              n_fail++;
              $display("FAIL arr_write: got addr=%h data=%h acc=%b strb=%h required addr=%h data=%h acc=%b strb=0",
                       arr_addr, arr_write_data, arr_write_access, arr_write_strb, ea.addr, ea.data, ea.access);
            end
          end
        end
      end
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d, input logic dirty);
    pl_addr = a; pl_data = d; pl_dirty = dirty; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic clear_array();
    arr_clr = 1'b1;
    @(posedge clk); #1;
    arr_clr = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output int acc_cyc);
    int guard;
    guard = 0;
    req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++; $display("FAIL accept_timeout: got req_ready=0 required 1");
    end
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    req_valid = 1'b0;
  endtask

  task automatic mem_accept(input int stall);
    int guard;
    logic [31:0] a0, d0;
    logic w0;
    guard = 0;
    while (!mem_req_valid && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    n_checks++;
    if (!mem_req_valid) begin
      n_fail++; $display("FAIL mem_req_timeout: got mem_req_valid=0 required 1");
    end else begin
      a0 = mem_req_addr; w0 = mem_req_write; d0 = mem_req_wdata;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== a0 || mem_req_write !== w0 ||
            mem_req_wdata !== d0 || resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_req_stable: got v=%b a=%h w=%b d=%h resp=%b required v=1 a=%h w=%b d=%h resp=0",
                   mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, resp_valid, a0, w0, d0);
        end
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || arr_write_valid !== 1'b0) begin
        n_fail++; $display("FAIL early_resp: got resp_valid=%b arr_write_valid=%b required 0/0", resp_valid, arr_write_valid);
      end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = data;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_addr = 32'h0000_0ABC;
    arr_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 arr_clr = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_resp: got ready=%b rv=%b rd=%h required 1/0/0", req_ready, resp_valid, resp_rdata);
    end
    if (arr_write_valid !== 1'b0 || arr_write_access !== 1'b0) begin
      n_fail++; $display("FAIL reset_arr: got wv=%b wa=%b required 0/0", arr_write_valid, arr_write_access);
    end
    if (mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 || mem_req_addr !== 32'd0 || mem_req_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_mem: got v=%b w=%b a=%h d=%h required 0/0/0/0",
                         mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata);
    end
    if (arr_addr !== 32'h0000_0ABC) begin
      n_fail++; $display("FAIL idle_arr_addr: got %h required 00000abc", arr_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_cold_load_then_hit();
    int t;
    exp_mem_q.push_back('{addr: 32'h100, wr: 1'b0, wdata: 32'd0});
    exp_aw_q.push_back('{addr: 32'h100, data: 32'hDEADBEEF, access: 1'b0});
    exp_resp_q.push_back(32'hDEADBEEF);
    issue(32'h100, 1'b0, 32'd0, 4'h0, t);
    mem_accept(0);
    mem_respond(2, 32'hDEADBEEF);
    exp_resp_q.push_back(32'hDEADBEEF);
    issue(32'h100, 1'b0, 32'd0, 4'h0, t);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL hit_latency: got resp_valid=%b mem_req_valid=%b required 1/0", resp_valid, mem_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int t;
    preload(32'h200, 32'hAABBCCDD, 1'b0);
    exp_aw_q.push_back('{addr: 32'h200, data: 32'hAABB3344, access: 1'b1});
    exp_resp_q.push_back(32'd0);
    issue(32'h200, 1'b1, 32'h11223344, 4'b0011, t);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || arr_write_access !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL store_hit: got rv=%b acc=%b memv=%b required 1/1/0", resp_valid, arr_write_access, mem_req_valid);
    end
    @(posedge clk); #1;
    // Zero strobe on a miss still allocates the line with the memory word.
    exp_mem_q.push_back('{addr: 32'h300, wr: 1'b0, wdata: 32'd0});
    exp_aw_q.push_back('{addr: 32'h300, data: 32'h12345678, access: 1'b1});
    exp_resp_q.push_back(32'd0);
    issue(32'h300, 1'b1, 32'hFFFFFFFF, 4'h0, t);
    mem_accept(0);
    mem_respond(1, 32'h12345678);
    exp_mem_q.push_back('{addr: 32'h304, wr: 1'b0, wdata: 32'd0});
    exp_aw_q.push_back('{addr: 32'h304, data: 32'hCAFE0304, access: 1'b1});
    exp_resp_q.push_back(32'd0);
    issue(32'h304, 1'b1, 32'hCAFEF00D, 4'b1100, t);
    mem_accept(1);
    mem_respond(0, 32'h01020304);
  endtask

  task automatic test_dirty_wb(input logic [31:0] vic, input logic [31:0] vdata,
                               input logic [31:0] a, input logic [31:0] fdata, input int stall);
    int t;
    preload(vic, vdata, 1'b1);
    exp_mem_q.push_back('{addr: vic, wr: 1'b1, wdata: vdata});
    exp_mem_q.push_back('{addr: a, wr: 1'b0, wdata: 32'd0});
    exp_aw_q.push_back('{addr: a, data: fdata, access: 1'b0});
    exp_resp_q.push_back(fdata);
    issue(a, 1'b0, 32'd0, 4'h0, t);
    mem_accept(stall);
    mem_accept(stall);
    mem_respond(stall, fdata);
  endtask

  task automatic test_reset_midop();
    int t;
    clear_array();
    exp_mem_q.push_back('{addr: 32'h600, wr: 1'b0, wdata: 32'd0});
    issue(32'h600, 1'b0, 32'd0, 4'h0, t);
    mem_accept(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h99999999;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || arr_write_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_midop: got ready=%b rv=%b wv=%b memv=%b required 1/0/0/0",
                         req_ready, resp_valid, arr_write_valid, mem_req_valid);
    end
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    preload(32'h10, 32'h0, 1'b0);
    exp_aw_q.push_back('{addr: 32'h10, data: 32'h13572468, access: 1'b1});
    exp_resp_q.push_back(32'd0);
    exp_resp_q.push_back(32'h13572468);
    issue(32'h10, 1'b1, 32'h13572468, 4'hF, t0);
    issue(32'h10, 1'b0, 32'd0, 4'h0, t1);
    n_checks++;
    if (t1 - t0 != 2) begin
      n_fail++; $display("FAIL back_to_back: got %0d cycles between accepts required 2", t1 - t0);
    end
    @(posedge clk); #1;
  endtask

`ifdef DCACHE_PERF_EN
  task automatic test_perf();
    int t;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_array();
    test_dirty_wb(32'h20, 32'h0A0B0C0D, 32'h420, 32'h5A5A5A5A, 0);
    exp_resp_q.push_back(32'h5A5A5A5A);
    issue(32'h420, 1'b0, 32'd0, 4'h0, t);
    exp_mem_q.push_back('{addr: 32'h24, wr: 1'b0, wdata: 32'd0});
    exp_aw_q.push_back('{addr: 32'h24, data: 32'h00C0FFEE, access: 1'b0});
    exp_resp_q.push_back(32'h00C0FFEE);
    issue(32'h24, 1'b0, 32'd0, 4'h0, t);
    mem_accept(0);
    mem_respond(0, 32'h00C0FFEE);
    exp_resp_q.push_back(32'h00C0FFEE);
    issue(32'h24, 1'b0, 32'd0, 4'h0, t);
    exp_resp_q.push_back(32'h5A5A5A5A);
    issue(32'h420, 1'b0, 32'd0, 4'h0, t);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (perf_hit !== 32'd3 || perf_miss !== 32'd2 || perf_wb !== 32'd1) begin
      n_fail++; $display("FAIL perf: got hit=%0d miss=%0d wb=%0d required 3/2/1", perf_hit, perf_miss, perf_wb);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish within 200us");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0; req_wdata = 32'd0; req_wstrb = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    arr_clr = 1'b0; pl_en = 1'b0; pl_dirty = 1'b0; pl_addr = 32'd0; pl_data = 32'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_cold_load_then_hit();
    test_store();
    test_dirty_wb(32'h100, 32'h5555AAAA, 32'h500, 32'h0BADF00D, 0);
    test_dirty_wb(32'h140, 32'h77778888, 32'h540, 32'h2468ACE0, 5);
    test_reset_midop();
    test_back_to_back();
`ifdef DCACHE_PERF_EN
    test_perf();
`endif
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_resp_q.size() != 0 || exp_mem_q.size() != 0 || exp_aw_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got resp=%0d mem=%0d aw=%0d pending required 0/0/0",
                         exp_resp_q.size(), exp_mem_q.size(), exp_aw_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
